pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Sequential pipeline hazard and stall controller for the 5-stage MIPS core. It sits beside the combinational decoder and owns all stage write-enables and flushes. It handles load-use/RAW stalls, data-cache miss freezes, multi-cycle MULT/DIV occupancy, taken-branch/jump flushes, and SYSCALL drain-then-halt. It also keeps a saturating stall-cycle counter.

## Interface
- `REG_ADDR_W`, 5, register-index width.
- `MULDIV_LAT`, 8, total EX-stage cycles for MULT/DIV (≥1).
- `DRAIN_DEPTH`, 3, cycles to drain EX/MEM/WB after SYSCALL (≥1).
- `CNT_W`, 32, stall counter width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_b` in 1: reset, asynchronous, active-low.
- `id_rs`, `id_rt` in REG_ADDR_W: ID source indices.
- `id_uses_rs`, `id_uses_rt` in 1: ID reads that source.
- `id_syscall` in 1: ID holds SYSCALL.
- `id_redirect` in 1: ID resolved taken branch or jump (J/JAL/JR).
- `ex_dest` in REG_ADDR_W, `ex_we` in 1, `ex_is_load` in 1, `ex_is_muldiv` in 1: EX-stage info.
- `mem_dest` in REG_ADDR_W, `mem_we` in 1: MEM-stage destination.
- `mem_req` in 1: MEM holds LW/LB/SW/SB.
- `mem_hit` in 1: cache completes the access this cycle.
- `pc_we`, `if_id_we`, `id_ex_we`, `ex_mem_we`, `mem_wb_we` out 1: stage register enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, `mem_wb_flush` out 1: load a bubble into that register.
- `halted` out 1: registered, sticky until reset.
- `stall_cnt` out CNT_W: saturating count of stalled cycles.

## Operation
- States: RUN, MD_BUSY, DRAIN, HALT. A down-counter `cnt` (width ⌈log2(max(MULDIV_LAT,DRAIN_DEPTH))⌉+1) is shared between MD_BUSY and DRAIN.
- A RAW match means `*_we` is set, `*_dest` is nonzero and equals a used ID source.
- Priority, highest first: HALT > miss freeze > MD_BUSY > load-use/RAW > DRAIN entry > redirect.
- **HALT:** all `*_we` are 0 and all flushes are 0. `halted` is 1.
- **Miss freeze**, when `mem_req & ~mem_hit` in any non-HALT state:
  - pc/if_id/id_ex/ex_mem enables are 0 and `mem_wb_flush` is 1.
  - State and `cnt` hold.
- **MD_BUSY entry:** in RUN with `ex_is_muldiv` and MULDIV_LAT>1, load `cnt`=MULDIV_LAT-2 and go to MD_BUSY.
  - In the entry cycle: pc/if_id/id_ex enables are 0 and `ex_mem_flush` is 1.
- **MD_BUSY:** the same freeze applies while `cnt`≠0, and `cnt` decrements.
  - When `cnt`=0, stages advance normally and the state returns to RUN.
  - EX occupancy is exactly MULDIV_LAT cycles. With MULDIV_LAT=1 there is no stall.
- **Load-use/RAW in RUN:** `pc_we`=`if_id_we`=0 and `id_ex_flush`=1. Downstream stages advance.
- **DRAIN entry:** in RUN with `id_syscall` and no stall, set `pc_we`=0 and `if_id_flush`=1, load `cnt`=DRAIN_DEPTH-1, and go to DRAIN.
- **DRAIN:**
  - `pc_we`=`if_id_we`=0 and `id_ex_flush`=1; downstream stages advance.
  - At `cnt`=0, go to HALT; `halted` rises in the next cycle.
- **Redirect:** `if_id_flush`=1 only when ID is not stalled (no RAW stall, freeze or MD_BUSY). A suppressed redirect is re-evaluated next cycle.
- Flush overrides `we` on the same register.
- **stall_cnt** increments each cycle `pc_we`=0 in RUN, MD_BUSY or DRAIN, and saturates at all-ones.

## Timing
- Enables and flushes are combinational from inputs and the current state, with no added latency.
- State, `cnt`, `halted` and `stall_cnt` update on the `clk` rising edge.
- Reset (`rst_b`=0, asynchronous):
  - State=RUN, `cnt`=0, `halted`=0, `stall_cnt`=0.
  - While reset is asserted, all `*_we`=0 and all flushes=0.
- Reset mid-MD_BUSY or mid-DRAIN aborts immediately. The first cycle after release is RUN.
- A load-use stall lasts 1 cycle with forwarding. Without forwarding, it lasts until the producer leaves MEM.
- `mem_hit` with `mem_req` releases the freeze in the same cycle.

## Configuration
- Macro: `PIPE_HAZARD_FWD_EN`.
- **Defined** (forwarding present): a RAW stall is raised only by an EX match with `ex_is_load`=1. MEM matches and non-load EX matches never stall.
- **Undefined:** any EX match or MEM match stalls. WB is write-before-read in the regfile and never stalls.

## Test plan
- **Load-use:** FWD_EN defined; `ex_is_load`=1, `ex_we`=1, `ex_dest`=5, `id_rs`=5, `id_uses_rs`=1 → exactly 1 cycle with `pc_we`=0, `id_ex_flush`=1; `stall_cnt` goes 0→1.
- **RAW without forwarding:** FWD_EN undefined; ALU writer to $7 in EX then MEM, ID reads $7 → 2 stall cycles. `ex_dest`=0 with a match on $0 → no stall.
- **MULDIV:** MULDIV_LAT=8 → 7 cycles of `ex_mem_flush`=1 and `pc_we`=0, then advance and return to RUN. A miss raised in cycle 3 for 4 cycles extends the total to 11 cycles.
- **Cache miss:** `mem_req`=1, `mem_hit`=0 for 5 cycles → 5 cycles of freeze with `mem_wb_flush`=1; release in the same cycle `mem_hit`=1.
- **Redirect:** `id_redirect`=1 during a load-use stall → no flush. Next cycle it gives `if_id_flush`=1.
- **SYSCALL and reset:** DRAIN_DEPTH=3 → `halted`=1 on the 4th cycle after entry and held. Asserting `rst_b` low mid-DRAIN clears `halted`, `stall_cnt` and state to RUN immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decoder-side inputs and stage-control outputs
// of the pipeline hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic                  id_syscall;
    logic                  id_redirect;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  ex_we;
    logic                  ex_is_load;
    logic                  ex_is_muldiv;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic                  mem_we;
    logic                  mem_req;
    logic                  mem_hit;
    logic                  pc_we;
    logic                  if_id_we;
    logic                  id_ex_we;
    logic                  ex_mem_we;
    logic                  mem_wb_we;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  ex_mem_flush;
    logic                  mem_wb_flush;
    logic                  halted;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt,
        output id_syscall, id_redirect,
        output ex_dest, ex_we, ex_is_load, ex_is_muldiv,
        output mem_dest, mem_we, mem_req, mem_hit,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
        input  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
        input  halted, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  id_syscall, id_redirect,
        input  ex_dest, ex_we, ex_is_load, ex_is_muldiv,
        input  mem_dest, mem_we, mem_req, mem_hit,
        output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
        output if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
        output halted, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/halt control for the 5-stage MIPS pipeline.
// Define PIPE_HAZARD_FWD_EN when the datapath forwards from EX/MEM.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MULDIV_LAT  = 8,
    parameter int DRAIN_DEPTH = 3,
    parameter int CNT_W       = 32
) (
    input logic               clk,
    input logic               rst_b,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int MAX_D = (MULDIV_LAT > DRAIN_DEPTH) ?
                           MULDIV_LAT : DRAIN_DEPTH;
    localparam int CW = $clog2(MAX_D) + 1;
    localparam bit MD_EN = (MULDIV_LAT > 1);
    localparam logic [CW-1:0] MD_LOAD = MD_EN ?
                                        CW'(MULDIV_LAT - 2) : '0;
    localparam logic [CW-1:0] DR_LOAD = CW'(DRAIN_DEPTH - 1);
    localparam logic [REG_ADDR_W-1:0] R_ZERO = '0;

    typedef enum logic [1:0] {RUN, MD_BUSY, DRAIN, HALT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_halted;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_freeze;
    logic             w_ex_match;
    logic             w_mem_match;
    logic             w_raw;
    logic             w_unused_sig;
    logic [4:0]       w_we;
    logic [3:0]       w_fl;

    assign w_freeze = bus.mem_req & ~bus.mem_hit;

    assign w_ex_match = bus.ex_we && (bus.ex_dest != R_ZERO) &&
        ((bus.id_uses_rs && (bus.ex_dest == bus.id_rs)) ||
         (bus.id_uses_rt && (bus.ex_dest == bus.id_rt)));

    assign w_mem_match = bus.mem_we && (bus.mem_dest != R_ZERO) &&
        ((bus.id_uses_rs && (bus.mem_dest == bus.id_rs)) ||
         (bus.id_uses_rt && (bus.mem_dest == bus.id_rt)));

`ifdef PIPE_HAZARD_FWD_EN
    assign w_raw        = w_ex_match & bus.ex_is_load;
    assign w_unused_sig = w_mem_match;
`else
    assign w_raw        = w_ex_match | w_mem_match;
    assign w_unused_sig = bus.ex_is_load;
`endif

    // w_we: pc, if_id, id_ex, ex_mem, mem_wb; w_fl: if_id .. mem_wb
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_we        = 5'b11111;
        w_fl        = 4'b0000;
        if (!rst_b) begin
            w_we = 5'b00000;
        end else if (r_state == HALT) begin
            w_we = 5'b00000;
        end else if (w_freeze) begin
            w_we = 5'b00001;
            w_fl = 4'b0001;
        end else if (r_state == MD_BUSY && r_cnt != '0) begin
            w_we      = 5'b00011;
            w_fl      = 4'b0010;
            w_cnt_nxt = r_cnt - 1'b1;
        end else if (r_state == DRAIN) begin
            w_we = 5'b00111;
            w_fl = 4'b0100;
            if (r_cnt == '0) begin
                w_state_nxt = HALT;
            end else begin
                w_cnt_nxt = r_cnt - 1'b1;
            end
        end else begin
            // RUN, or the MD_BUSY cycle in which the result leaves EX
            w_state_nxt = RUN;
            if (MD_EN && r_state == RUN && bus.ex_is_muldiv) begin
                w_we        = 5'b00011;
                w_fl        = 4'b0010;
                w_cnt_nxt   = MD_LOAD;
                w_state_nxt = MD_BUSY;
            end else if (w_raw) begin
                w_we = 5'b00111;
                w_fl = 4'b0100;
            end else begin
                if (bus.id_syscall) begin
                    w_we[4]     = 1'b0;
                    w_fl[3]     = 1'b1;
                    w_cnt_nxt   = DR_LOAD;
                    w_state_nxt = DRAIN;
                end
                if (bus.id_redirect) begin
                    w_fl[3] = 1'b1;
                end
            end
        end
        w_we[3:0] = w_we[3:0] & ~w_fl;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_halted    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_state_nxt == HALT) begin
                r_halted <= 1'b1;
            end
            if (!w_we[4] && r_state != HALT && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign bus.pc_we        = w_we[4];
    assign bus.if_id_we     = w_we[3];
    assign bus.id_ex_we     = w_we[2];
    assign bus.ex_mem_we    = w_we[1];
    assign bus.mem_wb_we    = w_we[0];
    assign bus.if_id_flush  = w_fl[3];
    assign bus.id_ex_flush  = w_fl[2];
    assign bus.ex_mem_flush = w_fl[1];
    assign bus.mem_wb_flush = w_fl[0];
    assign bus.halted       = r_halted;
    assign bus.stall_cnt    = r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: vector table, directed corner sequences and
// random stimulus against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
    localparam int RW = 5;
    localparam int MDL = 8;
    localparam int DRD = 3;
    localparam int CW = 32;
`ifdef PIPE_HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    // {pc,if_id,id_ex,ex_mem,mem_wb we ; if_id,id_ex,ex_mem,mem_wb flush}
    localparam logic [8:0] NORM = 9'b11111_0000;
    localparam logic [8:0] RED  = 9'b10111_1000;
    localparam logic [8:0] FRZ  = 9'b00000_0001;
    localparam logic [8:0] RAWS = 9'b00011_0100;
    localparam logic [8:0] MDE  = 9'b00001_0010;
    localparam logic [8:0] SYS  = 9'b00111_1000;
    localparam logic [8:0] DRN  = 9'b00011_0100;
    localparam logic [8:0] ZERO = 9'b00000_0000;

    logic clk;
    logic rst_b;
    int   n_chk;
    int   n_fail;

    pipe_hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(
        .REG_ADDR_W(RW), .MULDIV_LAT(MDL),
        .DRAIN_DEPTH(DRD), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_b(rst_b), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [4:0] rs, rt;
        logic urs, urt, sys, redir;
        logic [4:0] exd;
        logic exwe, exld, exmd;
        logic [4:0] memd;
        logic memwe, mreq, mhit;
        logic [8:0] exp;
    } vec_t;

    vec_t vt[19];

    function automatic vec_t mk(
        input logic [4:0] rs, rt, input logic urs, urt, sys, redir,
        input logic [4:0] exd, input logic exwe, exld, exmd,
        input logic [4:0] memd, input logic memwe, mreq, mhit,
        input logic [8:0] exp);
        vec_t v;
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
        v.sys = sys; v.redir = redir; v.exd = exd; v.exwe = exwe;
        v.exld = exld; v.exmd = exmd; v.memd = memd;
        v.memwe = memwe; v.mreq = mreq; v.mhit = mhit; v.exp = exp;
        return v;
    endfunction

    function automatic logic [8:0] outs();
        return {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we,
                bus.mem_wb_we, bus.if_id_flush, bus.id_ex_flush,
                bus.ex_mem_flush, bus.mem_wb_flush};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.id_rs = '0; bus.id_rt = '0;
        bus.id_uses_rs = 0; bus.id_uses_rt = 0;
        bus.id_syscall = 0; bus.id_redirect = 0;
        bus.ex_dest = '0; bus.ex_we = 0;
        bus.ex_is_load = 0; bus.ex_is_muldiv = 0;
        bus.mem_dest = '0; bus.mem_we = 0;
        bus.mem_req = 0; bus.mem_hit = 0;
    endtask

    task automatic apply(input vec_t v);
        bus.id_rs = v.rs; bus.id_rt = v.rt;
        bus.id_uses_rs = v.urs; bus.id_uses_rt = v.urt;
        bus.id_syscall = v.sys; bus.id_redirect = v.redir;
        bus.ex_dest = v.exd; bus.ex_we = v.exwe;
        bus.ex_is_load = v.exld; bus.ex_is_muldiv = v.exmd;
        bus.mem_dest = v.memd; bus.mem_we = v.memwe;
        bus.mem_req = v.mreq; bus.mem_hit = v.mhit;
    endtask

    task automatic do_reset(input bit check);
        @(negedge clk);
        rst_b = 1'b0;
        idle();
        #1;
        if (check) begin
            chk("rst_outs", outs(), ZERO);
            chk("rst_halted", bus.halted, 0);
            chk("rst_stall_cnt", bus.stall_cnt, 0);
        end
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic load_use(input logic [4:0] r);
        bus.ex_we = 1; bus.ex_is_load = 1; bus.ex_dest = r;
        bus.id_rs = r; bus.id_uses_rs = 1;
    endtask

    // Reference model: remaining-cycle counters per activity
    int  md_rem;
    int  dr_rem;
    bit  m_halt;
    longint m_stall;

    function automatic bit hits(input logic [4:0] d, input logic we);
        return we && d != 0 &&
               ((bus.id_uses_rs && bus.id_rs == d) ||
                (bus.id_uses_rt && bus.id_rt == d));
    endfunction

    task automatic model_reset();
        md_rem = 0; dr_rem = 0; m_halt = 0; m_stall = 0;
    endtask

    task automatic model_step(output logic [8:0] e);
        logic [4:0] we;
        logic [3:0] fl;
        bit raw, halt_next, md_last;
        we = '1; fl = '0; halt_next = 0;
        raw = FWD ? (hits(bus.ex_dest, bus.ex_we) && bus.ex_is_load)
                  : (hits(bus.ex_dest, bus.ex_we) ||
                     hits(bus.mem_dest, bus.mem_we));
        if (m_halt) begin
            we = '0;
        end else if (bus.mem_req && !bus.mem_hit) begin
            we[4:1] = '0; fl[0] = 1;
        end else if (md_rem > 1) begin
            we[4:2] = '0; fl[1] = 1; md_rem--;
        end else if (dr_rem > 0) begin
            we[4:3] = '0; fl[2] = 1; dr_rem--;
            halt_next = (dr_rem == 0);
        end else begin
            md_last = (md_rem == 1);
            md_rem = 0;
            if (!md_last && bus.ex_is_muldiv && MDL > 1) begin
                we[4:2] = '0; fl[1] = 1; md_rem = MDL - 1;
            end else if (raw) begin
                we[4:3] = '0; fl[2] = 1;
            end else begin
                if (bus.id_syscall) begin
                    we[4] = 0; fl[3] = 1; dr_rem = DRD;
                end
                if (bus.id_redirect) fl[3] = 1;
            end
        end
        we[3:0] = we[3:0] & ~fl;
        if (!m_halt && !we[4] && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (halt_next) m_halt = 1;
        e = {we, fl};
    endtask

    initial begin
        int n, nf;
        bit done;
        logic [8:0] e;
        n_chk = 0;
        n_fail = 0;
        rst_b = 1'b0;
        idle();
        vt[0]  = mk(0,0,0,0,0,0, 0,0,0,0, 0,0,0,0, NORM);
        vt[1]  = mk(0,0,0,0,0,1, 0,0,0,0, 0,0,0,0, RED);
        vt[2]  = mk(0,0,0,0,0,0, 0,0,0,0, 0,0,1,0, FRZ);
        vt[3]  = mk(0,0,0,0,0,0, 0,0,0,0, 0,0,1,1, NORM);
        vt[4]  = mk(5,0,1,0,0,0, 5,1,1,0, 0,0,0,0, RAWS);
        vt[5]  = mk(0,9,0,1,0,0, 9,1,1,0, 0,0,0,0, RAWS);
        vt[6]  = mk(7,0,1,0,0,0, 7,1,0,0, 0,0,0,0, FWD ? NORM : RAWS);
        vt[7]  = mk(0,7,0,1,0,0, 0,0,0,0, 7,1,0,0, FWD ? NORM : RAWS);
        vt[8]  = mk(0,0,1,1,0,0, 0,1,1,0, 0,1,0,0, NORM);
        vt[9]  = mk(5,0,0,0,0,0, 5,1,1,0, 0,0,0,0, NORM);
        vt[10] = mk(5,0,1,0,0,0, 5,0,1,0, 0,0,0,0, NORM);
        vt[11] = mk(0,0,0,0,0,0, 0,0,0,1, 0,0,0,0, MDE);
        vt[12] = mk(0,0,0,0,1,0, 0,0,0,0, 0,0,0,0, SYS);
        vt[13] = mk(5,0,1,0,1,0, 5,1,1,0, 0,0,0,0, RAWS);
        vt[14] = mk(5,0,1,0,0,1, 5,1,1,0, 0,0,0,0, RAWS);
        vt[15] = mk(5,0,1,0,1,1, 5,1,1,1, 0,0,1,0, FRZ);
        vt[16] = mk(5,0,1,0,0,0, 5,1,1,1, 0,0,0,0, MDE);
        vt[17] = mk(0,0,0,0,1,1, 0,0,0,0, 0,0,0,0, SYS);
        vt[18] = mk(3,0,1,0,0,1, 0,0,0,0, 3,1,0,0, FWD ? RED : RAWS);

        do_reset(1);
        for (int i = 0; i < 19; i++) begin
            do_reset(0);
            @(negedge clk);
            apply(vt[i]);
            #1;
            chk($sformatf("tbl%0d", i), outs(), vt[i].exp);
        end

        // Load-use with a redirect waiting behind it
        do_reset(0);
        @(negedge clk);
        idle(); load_use(5); bus.id_redirect = 1; #1;
        chk("lu_c0_outs", outs(), RAWS);
        chk("lu_c0_cnt", bus.stall_cnt, 0);
        @(negedge clk);
        idle(); bus.id_rs = 5; bus.id_uses_rs = 1; bus.id_redirect = 1;
        bus.mem_dest = 5; bus.mem_we = 1; #1;
        chk("lu_c1_outs", outs(), FWD ? RED : RAWS);
        chk("lu_c1_cnt", bus.stall_cnt, 1);
        @(negedge clk);
        bus.mem_we = 0; #1;
        chk("lu_c2_outs", outs(), RED);
        chk("lu_c2_cnt", bus.stall_cnt, FWD ? 1 : 2);

        // MULT/DIV occupancy
        do_reset(0);
        n = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            idle(); bus.ex_is_muldiv = 1; #1;
            if (bus.pc_we) done = 1;
            else if (bus.ex_mem_flush) n++;
        end
        chk("md_done", done, 1);
        chk("md_stall_cycles", n, MDL - 1);
        chk("md_adv_flush", bus.ex_mem_flush, 0);
        chk("md_stall_cnt", bus.stall_cnt, MDL - 1);
        @(negedge clk);
        #1;
        chk("md_back_in_run", outs(), MDE);

        // MULT/DIV with a 4-cycle miss starting in cycle 3
        do_reset(0);
        n = 0; nf = 0; done = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            idle(); bus.ex_is_muldiv = 1;
            bus.mem_req = (i >= 3 && i < 7); #1;
            if (bus.pc_we) done = 1;
            else n++;
            if (bus.mem_wb_flush) nf++;
        end
        chk("mdm_done", done, 1);
        chk("mdm_stall_cycles", n, 11);
        chk("mdm_mwb_flushes", nf, 4);

        // Cache miss freeze, released by the hit
        do_reset(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            idle(); bus.mem_req = 1; #1;
            chk($sformatf("miss%0d_outs", i), outs(), FRZ);
        end
        @(negedge clk);
        bus.mem_hit = 1; #1;
        chk("miss_release", outs(), NORM);
        chk("miss_cnt", bus.stall_cnt, 5);

        // SYSCALL drain then halt
        do_reset(0);
        @(negedge clk);
        idle(); bus.id_syscall = 1; #1;
        chk("sys_entry", outs(), SYS);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            idle(); #1;
            chk($sformatf("drain%0d_outs", i), outs(), DRN);
            chk($sformatf("drain%0d_halted", i), bus.halted, 0);
        end
        @(negedge clk);
        #1;
        chk("halt_halted", bus.halted, 1);
        chk("halt_outs", outs(), ZERO);
        @(negedge clk);
        load_use(4); bus.ex_is_muldiv = 1; bus.id_redirect = 1; #1;
        chk("halt_hold", bus.halted, 1);
        chk("halt_outs2", outs(), ZERO);
        chk("halt_cnt", bus.stall_cnt, 4);

        // Reset in the middle of DRAIN
        do_reset(0);
        @(negedge clk);
        idle(); bus.id_syscall = 1;
        @(negedge clk);
        idle();
        @(negedge clk);
        rst_b = 0; #1;
        chk("rdr_halted", bus.halted, 0);
        chk("rdr_cnt", bus.stall_cnt, 0);
        chk("rdr_outs", outs(), ZERO);
        @(negedge clk);
        rst_b = 1;
        @(negedge clk);
        #1;
        chk("rdr_run", outs(), NORM);
        chk("rdr_cnt2", bus.stall_cnt, 0);

        // Random stimulus against the reference model
        do_reset(0);
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_b = 1;
            bus.id_rs = 5'($urandom_range(3));
            bus.id_rt = 5'($urandom_range(3));
            bus.id_uses_rs = 1'($urandom_range(1));
            bus.id_uses_rt = 1'($urandom_range(1));
            bus.id_syscall = ($urandom_range(49) == 0);
            bus.id_redirect = ($urandom_range(4) == 0);
            bus.ex_dest = 5'($urandom_range(3));
            bus.ex_we = 1'($urandom_range(1));
            bus.ex_is_load = ($urandom_range(2) == 0);
            bus.ex_is_muldiv = ($urandom_range(11) == 0);
            bus.mem_dest = 5'($urandom_range(3));
            bus.mem_we = 1'($urandom_range(1));
            bus.mem_req = ($urandom_range(2) == 0);
            bus.mem_hit = ($urandom_range(4) < 3);
            if ($urandom_range(99) == 0 ||
                (m_halt && $urandom_range(3) == 0)) begin
                rst_b = 0; #1;
                chk("rnd_rst_outs", outs(), ZERO);
                chk("rnd_rst_halted", bus.halted, 0);
                model_reset();
            end else begin
                #1;
                chk("rnd_halted", bus.halted, m_halt);
                chk("rnd_stall_cnt", bus.stall_cnt, m_stall);
                model_step(e);
                chk("rnd_outs", outs(), e);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
